// File: rtl/melody_player.sv
// rtl/melody_player.sv - piezo melody sequencer: stored-song ROM, tone/beat counters, one-shot or looped playback
// Optional inter-note silence is built when MELODY_PLAYER_GAP_EN is defined.
module melody_player #(
    parameter int  HALF_W     = 12,
    parameter int  BEAT_TICKS = 200000,
    parameter int  LEN        = 32,
    parameter int  NUM_SONGS  = 2,
    parameter int  GAP_TICKS  = 2000,
    localparam int SEL_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int IDX_W      = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [SEL_W-1:0] song_sel,
    input  logic             loop,
    output logic             piezo,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] note_idx
);

    localparam int BEAT_W = $clog2(4 * BEAT_TICKS + 1);

    if (LEN < 2 || NUM_SONGS < 1 || GAP_TICKS < 0 || HALF_W < 11) begin : g_bad_cfg
        $error("melody_player: unsupported parameter set");
    end

`ifdef MELODY_PLAYER_GAP_EN
    localparam int               GAP_W    = $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1
`ifdef MELODY_PLAYER_GAP_EN
        , GAP = 2'd2
`endif
    } state_t;

    // Song 0 is the alarm tune; higher songs are short chirp patterns with small half-periods.
    function automatic logic [HALF_W+1:0] rom_word(input int song, input int idx);
        int h;
        int d;
        h = 0;
        d = idx % 4;
        if (song == 0) begin
            case (idx)
                0, 1:    begin h = 957;  d = 0; end
                2:       begin h = 1136; d = 1; end
                3:       begin h = 0;    d = 0; end
                default: begin
                    case (idx % 8)
                        0:       h = 1136;
                        1:       h = 1012;
                        2:       h = 902;
                        3:       h = 851;
                        4:       h = 758;
                        5:       h = 676;
                        6:       h = 602;
                        default: h = 0;
                    endcase
                end
            endcase
        end else begin
            h = (idx % 6 == 5) ? 0 : 4 * song + idx % 6;
            d = (idx + song) % 4;
        end
        return {HALF_W'(h), 2'(d)};
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   song_q, song_d;
    logic               loop_q, loop_d;
    logic               piezo_q, piezo_d;
    logic               done_q, done_d;
    logic [BEAT_W-1:0]  beat_q, beat_d, beat_last;
    logic [HALF_W-1:0]  tone_q, tone_d, half;
    logic [1:0]         dur;
    logic [HALF_W+1:0]  word;
    logic               adv, abort;
`ifdef MELODY_PLAYER_GAP_EN
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        song_d    = song_q;
        loop_d    = loop_q;
        piezo_d   = piezo_q;
        done_d    = 1'b0;
        beat_d    = beat_q;
        tone_d    = tone_q;
        adv       = 1'b0;
        abort     = 1'b0;
`ifdef MELODY_PLAYER_GAP_EN
        gap_d     = gap_q;
`endif
        word      = rom_word(int'(song_q), int'(idx_q));
        half      = word[HALF_W+1:2];
        dur       = word[1:0];
        beat_last = BEAT_W'((int'(dur) + 1) * BEAT_TICKS - 1);

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = TONE;
                    song_d  = (int'(song_sel) < NUM_SONGS) ? song_sel : '0;
                    loop_d  = loop;
                end
            end
            TONE: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (beat_q == beat_last) begin
                    piezo_d = 1'b0;
                    tone_d  = '0;
                    beat_d  = '0;
`ifdef MELODY_PLAYER_GAP_EN
                    state_d = GAP;
                    gap_d   = '0;
`else
                    adv     = 1'b1;
`endif
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (half == '0) begin
                        piezo_d = 1'b0;
                        tone_d  = '0;
                    end else if (tone_q == half) begin
                        piezo_d = ~piezo_q;
                        tone_d  = '0;
                    end else begin
                        tone_d = tone_q + HALF_W'(1);
                    end
                end
            end
`ifdef MELODY_PLAYER_GAP_EN
            GAP: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    adv = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            default: abort = 1'b1;
        endcase

        if (adv) begin
            if (idx_q == IDX_W'(LEN - 1)) begin
                idx_d = '0;
                if (loop_q) begin
                    state_d = TONE;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = TONE;
            end
        end

        // Abort leaves every counter cleared so the next start begins from a clean note.
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            piezo_d = 1'b0;
            tone_d  = '0;
            beat_d  = '0;
`ifdef MELODY_PLAYER_GAP_EN
            gap_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            loop_q  <= 1'b0;
            piezo_q <= 1'b0;
            done_q  <= 1'b0;
            beat_q  <= '0;
            tone_q  <= '0;
`ifdef MELODY_PLAYER_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            loop_q  <= loop_d;
            piezo_q <= piezo_d;
            done_q  <= done_d;
            beat_q  <= beat_d;
            tone_q  <= tone_d;
`ifdef MELODY_PLAYER_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign piezo    = piezo_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign note_idx = idx_q;

endmodule
